// File: rtl/wb_arb_pkg.sv
// wb_arb_pkg: shared widths, write-request struct and grant encoding for wb_port_arbiter
package wb_arb_pkg;
  localparam int XLEN = 32;
  localparam int REG_ADDR_W = 5;
  localparam int DEF_STARVE_LIMIT = 4;
  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0] data;
  } wb_req_t;
  typedef enum logic [1:0] {GNT_NONE, GNT_PIPE, GNT_LU} gnt_e;
endpackage

// File: rtl/wb_port_arbiter_if.sv
// wb_port_arbiter_if: writeback/long-latency/register-file signal bundle
// slave  : arbiter side (takes pipe_*, lu_*, chk_*; drives lu_ready, stall_pipe, rs*_pending, rf_*)
// master : core side (the reverse)
interface wb_port_arbiter_if;
  import wb_arb_pkg::*;
  logic pipe_valid;
  logic [REG_ADDR_W-1:0] pipe_rd;
  logic [XLEN-1:0] pipe_data;
  logic lu_issue;
  logic [REG_ADDR_W-1:0] lu_issue_rd;
  logic lu_valid;
  logic [REG_ADDR_W-1:0] lu_rd;
  logic [XLEN-1:0] lu_data;
  logic lu_ready;
  logic stall_pipe;
  logic [REG_ADDR_W-1:0] chk_rs1;
  logic [REG_ADDR_W-1:0] chk_rs2;
  logic rs1_pending;
  logic rs2_pending;
  logic rf_we;
  logic [REG_ADDR_W-1:0] rf_rd;
  logic [XLEN-1:0] rf_wdata;
  modport slave (
    input pipe_valid, pipe_rd, pipe_data, lu_issue, lu_issue_rd, lu_valid, lu_rd, lu_data, chk_rs1, chk_rs2,
    output lu_ready, stall_pipe, rs1_pending, rs2_pending, rf_we, rf_rd, rf_wdata
  );
  modport master (
    output pipe_valid, pipe_rd, pipe_data, lu_issue, lu_issue_rd, lu_valid, lu_rd, lu_data, chk_rs1, chk_rs2,
    input lu_ready, stall_pipe, rs1_pending, rs2_pending, rf_we, rf_rd, rf_wdata
  );
endinterface

// File: rtl/wb_arb_fifo.sv
// wb_arb_fifo: synchronous FIFO of wb_req_t buffering long-latency results
// clk, rst_n (async active-low); push/din, pop/dout (head, show-ahead); full, empty
module wb_arb_fifo
  import wb_arb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input logic clk,
  input logic rst_n,
  input logic push,
  input wb_req_t din,
  input logic pop,
  output wb_req_t dout,
  output logic full,
  output logic empty
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0] wp, rp;
  wb_req_t mem [DEPTH];
  // extra pointer MSB distinguishes full from empty when the indices match
  assign empty = wp == rp;
  assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign dout = mem[rp[AW-1:0]];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push && !full) wp <= wp + (AW+1)'(1);
      if (pop && !empty) rp <= rp + (AW+1)'(1);
    end
  always_ff @(posedge clk)
    if (push && !full) mem[wp[AW-1:0]] <= din;
endmodule

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the register-file write port between writeback and a long-latency unit
// clk, rst_n (async active-low); bus (wb_port_arbiter_if.slave) carries pipe_*, lu_*, chk_*, rf_* signals
// WB_ARB_BYPASS_EN: when defined, an LU result meeting an empty FIFO and idle pipe is written directly
module wb_port_arbiter #(
  parameter int BUF_DEPTH = 2,
  parameter int STARVE_LIMIT = wb_arb_pkg::DEF_STARVE_LIMIT
) (
  input logic clk,
  input logic rst_n,
  wb_port_arbiter_if.slave bus
);
  import wb_arb_pkg::*;
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam int NREG = 2 ** REG_ADDR_W;
  wb_req_t head, lu_req, pipe_req, win;
  logic full, empty, stall, byp, head_gnt, push;
  logic [CW-1:0] cnt;
  logic [NREG-1:0] mask, set_m, clr_m;
  gnt_e gnt;
  assign lu_req = wb_req_t'{rd: bus.lu_rd, data: bus.lu_data};
  assign pipe_req = wb_req_t'{rd: bus.pipe_rd, data: bus.pipe_data};
`ifdef WB_ARB_BYPASS_EN
  assign byp = empty && !bus.pipe_valid && bus.lu_valid;
`else
  assign byp = 1'b0;
`endif
  assign stall = !empty && cnt == CW'(STARVE_LIMIT);
  assign bus.stall_pipe = stall;
  assign bus.lu_ready = !full;
  // a bypassed result completes its handshake without entering the FIFO
  assign push = bus.lu_valid && !full && !byp;
  always_comb gnt = stall ? GNT_LU : bus.pipe_valid ? GNT_PIPE : (!empty || byp) ? GNT_LU : GNT_NONE;
  assign head_gnt = gnt == GNT_LU && !empty;
  assign win = gnt == GNT_PIPE ? pipe_req : empty ? lu_req : head;
  assign set_m = NREG'(bus.lu_issue && bus.lu_issue_rd != '0) << bus.lu_issue_rd;
  assign clr_m = NREG'(gnt == GNT_LU) << win.rd;
  assign bus.rs1_pending = mask[bus.chk_rs1];
  assign bus.rs2_pending = mask[bus.chk_rs2];
  wb_arb_fifo #(.DEPTH(BUF_DEPTH)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .push(push),
    .din(lu_req),
    .pop(head_gnt),
    .dout(head),
    .full(full),
    .empty(empty)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt <= '0;
      mask <= '0;
      bus.rf_we <= 1'b0;
      bus.rf_rd <= '0;
      bus.rf_wdata <= '0;
    end else begin
      cnt <= (empty || head_gnt) ? '0 : cnt == CW'(STARVE_LIMIT) ? cnt : cnt + CW'(1);
      // set after clear so a same-cycle reissue of the same rd stays pending
      mask <= (mask & ~clr_m) | set_m;
      bus.rf_we <= gnt != GNT_NONE && win.rd != '0;
      if (gnt != GNT_NONE) begin
        bus.rf_rd <= win.rd;
        bus.rf_wdata <= win.data;
      end
    end
  a_pipe_rd_not_pending: assert property (@(posedge clk) disable iff (!rst_n) !(bus.pipe_valid && mask[bus.pipe_rd]));
endmodule

// File: doc/wb_port_arbiter.md
# wb_port_arbiter

Shares the single register-file write port of the pipelined RISC-V core between the in-order writeback stage (the selected ALU/load/PC+4 result) and a long-latency execution unit (multiplier/divider) that completes out of order. It buffers long-latency results, arbitrates the write port with anti-starvation, and keeps a pending-destination scoreboard that the hazard unit uses to stall dependent instructions. All register-file write controls come from this block.

## Interface
- XLEN, 32, data width
- REG_ADDR_W, 5, register index width
- BUF_DEPTH, 2, long-latency result FIFO depth (power of 2, ≥2)
- STARVE_LIMIT, 4, cycles a buffered result may wait before forcing a pipeline stall

- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- pipe_valid  in  1  writeback stage holds a register write this cycle
- pipe_rd  in  REG_ADDR_W  writeback destination
- pipe_data  in  XLEN  writeback value (Result)
- lu_issue  in  1  long-latency op dispatched this cycle
- lu_issue_rd  in  REG_ADDR_W  its destination
- lu_valid  in  1  long-latency result offered
- lu_rd  in  REG_ADDR_W  result destination
- lu_data  in  XLEN  result value
- lu_ready  out  1  result accepted when lu_valid & lu_ready
- stall_pipe  out  1  writeback stage must hold its request this cycle
- chk_rs1, chk_rs2  in  REG_ADDR_W  source registers of decoding instruction
- rs1_pending, rs2_pending  out  1  source awaits a long-latency result
- rf_we  out  1  register-file write enable (registered)
- rf_rd  out  REG_ADDR_W  write address (registered)
- rf_wdata  out  XLEN  write data (registered)

## Operation
- Reset: FIFO empty, scoreboard cleared, starve counter 0; rf_we=0, rf_rd=0, rf_wdata=0; lu_ready=1, stall_pipe=0.
- lu_ready = FIFO not full, combinational.
- Per-cycle arbitration, one write granted:
  - FIFO non-empty and starve counter == STARVE_LIMIT: grant FIFO head, stall_pipe=1.
  - Otherwise pipe_valid: grant pipe; FIFO head waits and the counter increments if FIFO is non-empty.
  - Otherwise FIFO non-empty: grant FIFO head.
  - Otherwise no write.
- A stalled pipe request is not consumed; the pipeline re-presents it unchanged the following cycle.
- Starve counter clears when the head is granted or the FIFO is empty, and saturates at STARVE_LIMIT.
- Granted writes with rd=0 produce rf_we=0. The FIFO still pops and the scoreboard still clears.
- Scoreboard is a 2^REG_ADDR_W-bit pending mask. lu_issue with rd≠0 sets the bit. A granted FIFO write clears the bit for its rd. Set and clear of the same rd in one cycle: set wins. Bit 0 is never set.
- rsN_pending = mask[chk_rsN], combinational.
- Enqueue and dequeue in the same cycle are allowed, including when the FIFO is full: lu_ready reflects the pre-pop state, so no enqueue occurs when full.
- pipe_valid to an rd whose bit is pending is a protocol violation; flag it with a simulation assertion.

## Timing
- Pipe write presented in cycle C: rf_we in cycle C+1.
- LU result accepted at the edge ending cycle C: earliest rf_we in cycle C+2 (FIFO head arbitrated in C+1).
- Worst-case wait while pipe writes every cycle: STARVE_LIMIT cycles, then a 1-cycle forced stall.
- stall_pipe and lu_ready are combinational from registered state only (no input-to-output path).
- Asynchronous reset mid-operation discards buffered results and pending bits immediately.

## Configuration
- WB_ARB_BYPASS_EN defined: when the FIFO is empty, pipe_valid=0, and lu_valid=1, the LU result is granted directly without being enqueued. Latency is lu_valid in cycle C to rf_we in cycle C+1, and the scoreboard clears in that cycle.
- Undefined: all LU results pass through the FIFO (latency per Timing).

## Structure
- Package wb_arb_pkg holds:
  - XLEN and REG_ADDR_W defaults
  - STARVE_LIMIT default
  - wb_req_t struct {rd, data}
  - grant encoding enum {GNT_NONE, GNT_PIPE, GNT_LU}
- Sub-module wb_arb_fifo: synchronous FIFO of wb_req_t with full/empty, depth BUF_DEPTH, pointer wrap by extra MSB.

## Test plan
- Reset: rst_n low mid-traffic → rf_we=0, lu_ready=1, both pending outputs 0, FIFO empty after release.
- Pipe only: pipe_valid, rd=5, data=0x1234 in cycle C → rf_we=1, rf_rd=5, rf_wdata=0x1234 in C+1.
- Starvation: lu_issue rd=7; LU result 0xDEAD; pipe_valid every cycle → after 4 waiting cycles stall_pipe=1 for 1 cycle, rf writes rd=7 with 0xDEAD, rs pending for 7 drops.
- FIFO full: two LU results held under continuous pipe writes → lu_ready=0 and a third result is not accepted; it is accepted only after a pop.
- Scoreboard race: lu_issue rd=3 in the same cycle as the previous rd=3 result is written → rs1_pending(chk_rs1=3) stays 1.
- x0 and bypass: LU result rd=0 → no rf_we, FIFO pops; with WB_ARB_BYPASS_EN and an idle pipe, LU rd=9 in cycle C → rf_we in C+1.
